// File: rtl/sram_spi_arbiter.sv
// Single-port audio SRAM shared between the SPI register path and the audio datapath.
// Audio has priority; a wait counter bounds SPI starvation and SPI reads are prefetched.
module sram_spi_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int RD_LATENCY = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        page,
  input  logic              spi_rd_mode,
  input  logic [7:0]        start_addr,
  input  logic              addr_load_stb,
  input  logic              spi_wr_stb,
  input  logic [DATA_W-1:0] spi_wr_data,
  input  logic              spi_rd_stb,
  output logic [DATA_W-1:0] spi_rd_data,
  input  logic              aud_req,
  input  logic              aud_we,
  input  logic [ADDR_W-1:0] aud_addr,
  input  logic [DATA_W-1:0] aud_wdata,
  output logic              aud_gnt,
  output logic [DATA_W-1:0] aud_rdata,
  output logic              aud_rvalid,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  input  logic              clr_err,
  output logic              wr_overflow,
  output logic              rd_underrun,
  output logic              spi_busy
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  typedef enum logic {S_IDLE, S_RD_WAIT} state_t;

  state_t            r_state;
  logic [2:0]        r_cnt;
  logic [ADDR_W-1:0] r_ptr, r_wr_addr, r_sram_addr;
  logic [DATA_W-1:0] r_wr_data, r_sram_wdata, r_spi_rd_data, r_aud_rdata;
  logic              r_wr_full, r_pf_pend, r_rd_spi, r_rd_aud, r_stale;
  logic [WAIT_W-1:0] r_wait;
  logic              r_sram_en, r_sram_we, r_aud_gnt, r_aud_rvalid;
  logic              r_wr_ovf, r_rd_unr;

  logic              w_idle, w_aud_el, w_spi_el, w_spi_win, w_aud_win;
  logic              w_wr_iss, w_pf_iss, w_wr_cap, w_capture;
  logic [ADDR_W-1:0] w_ptr_cap, w_ptr_nxt;

  // Offset wraps inside the page; the page bits never change.
  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return {p[ADDR_W-1:8], p[7:0] + 8'd1};
  endfunction

  assign w_idle    = (r_state == S_IDLE);
  assign w_aud_el  = aud_req & ~r_aud_gnt;
  assign w_spi_el  = r_wr_full | r_pf_pend;
  assign w_spi_win = w_idle & w_spi_el & (~w_aud_el | (r_wait == WAIT_W'(MAX_WAIT)));
  assign w_aud_win = w_idle & w_aud_el & ~w_spi_win;
  assign w_wr_iss  = w_spi_win & r_wr_full;
  assign w_pf_iss  = w_spi_win & ~r_wr_full;
  assign w_wr_cap  = spi_wr_stb & ~r_wr_full;
  // The issue cycle itself does not count toward the read latency.
  assign w_capture = (r_state == S_RD_WAIT) & ~r_sram_en & (r_cnt == 3'd1);

  // A write strobe takes the current pointer; a prefetch issuing alongside it takes the next one.
  assign w_ptr_cap = w_wr_cap ? ptr_inc(r_ptr) : r_ptr;
  assign w_ptr_nxt = addr_load_stb ? ADDR_W'({page, start_addr})
                   : (w_pf_iss ? ptr_inc(w_ptr_cap) : w_ptr_cap);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_ptr         <= '0;
      r_wr_addr     <= '0;
      r_wr_data     <= '0;
      r_wr_full     <= 1'b0;
      r_pf_pend     <= 1'b0;
      r_rd_spi      <= 1'b0;
      r_rd_aud      <= 1'b0;
      r_stale       <= 1'b0;
      r_wait        <= '0;
      r_sram_en     <= 1'b0;
      r_sram_we     <= 1'b0;
      r_sram_addr   <= '0;
      r_sram_wdata  <= '0;
      r_spi_rd_data <= '0;
      r_aud_rdata   <= '0;
      r_aud_gnt     <= 1'b0;
      r_aud_rvalid  <= 1'b0;
      r_wr_ovf      <= 1'b0;
      r_rd_unr      <= 1'b0;
    end else begin
      r_sram_en    <= 1'b0;
      r_aud_gnt    <= 1'b0;
      r_aud_rvalid <= 1'b0;
      r_ptr        <= w_ptr_nxt;

      if (w_wr_cap) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= spi_wr_data;
      end
      r_wr_full <= r_wr_full ? ~w_wr_iss : w_wr_cap;
      r_pf_pend <= (r_pf_pend & ~w_pf_iss) | spi_rd_stb | (addr_load_stb & spi_rd_mode);

      if (spi_wr_stb & r_wr_full)                 r_wr_ovf <= 1'b1;
      else if (clr_err)                           r_wr_ovf <= 1'b0;
      if (spi_rd_stb & (r_pf_pend | r_rd_spi))    r_rd_unr <= 1'b1;
      else if (clr_err)                           r_rd_unr <= 1'b0;

      if (w_spi_win)                 r_wait <= '0;
      else if (w_idle & w_spi_el)    r_wait <= r_wait + 1'b1;

      if (w_capture)                                   r_stale <= 1'b0;
      else if (addr_load_stb & (r_rd_spi | w_pf_iss))  r_stale <= 1'b1;

      case (r_state)
        S_IDLE: begin
          if (w_wr_iss) begin
            r_sram_en    <= 1'b1;
            r_sram_we    <= 1'b1;
            r_sram_addr  <= r_wr_addr;
            r_sram_wdata <= r_wr_data;
          end else if (w_pf_iss) begin
            r_sram_en   <= 1'b1;
            r_sram_we   <= 1'b0;
            r_sram_addr <= w_ptr_cap;
            r_rd_spi    <= 1'b1;
            r_cnt       <= 3'(RD_LATENCY);
            r_state     <= S_RD_WAIT;
          end else if (w_aud_win) begin
            r_sram_en    <= 1'b1;
            r_sram_we    <= aud_we;
            r_sram_addr  <= aud_addr;
            r_sram_wdata <= aud_wdata;
            r_aud_gnt    <= 1'b1;
            if (!aud_we) begin
              r_rd_aud <= 1'b1;
              r_cnt    <= 3'(RD_LATENCY);
              r_state  <= S_RD_WAIT;
            end
          end
        end
        S_RD_WAIT: begin
          if (!r_sram_en) r_cnt <= r_cnt - 3'd1;
          if (w_capture) begin
            r_state  <= S_IDLE;
            r_rd_aud <= 1'b0;
            r_rd_spi <= 1'b0;
            if (r_rd_aud) begin
              r_aud_rdata  <= sram_rdata;
              r_aud_rvalid <= 1'b1;
            end else if (!r_stale && !addr_load_stb) begin
              r_spi_rd_data <= sram_rdata;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sram_en     = r_sram_en;
  assign sram_we     = r_sram_we;
  assign sram_addr   = r_sram_addr;
  assign sram_wdata  = r_sram_wdata;
  assign aud_gnt     = r_aud_gnt;
  assign aud_rdata   = r_aud_rdata;
  assign aud_rvalid  = r_aud_rvalid;
  assign spi_rd_data = r_spi_rd_data;
  assign wr_overflow = r_wr_ovf;
  assign rd_underrun = r_rd_unr;
  assign spi_busy    = r_wr_full | r_pf_pend | r_rd_spi;

endmodule

// File: tb/tb_sram_spi_arbiter.sv
// Directed bench for sram_spi_arbiter with a 2-cycle-latency SRAM model.
module tb_sram_spi_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  page = 8'h00, start_addr = 8'h00, spi_wr_data = 8'h00, aud_wdata = 8'h00;
  logic        spi_rd_mode = 1'b0, addr_load_stb = 1'b0, spi_wr_stb = 1'b0, spi_rd_stb = 1'b0;
  logic        aud_req = 1'b0, aud_we = 1'b0, clr_err = 1'b0;
  logic [15:0] aud_addr = 16'h0000;
  logic [7:0]  spi_rd_data, aud_rdata, sram_wdata, sram_rdata;
  logic        aud_gnt, aud_rvalid, sram_en, sram_we, wr_overflow, rd_underrun, spi_busy;
  logic [15:0] sram_addr;

  int checks = 0;
  int errors = 0;
  int rvalid_cnt = 0;
  int consec = 0;
  logic prev_gnt = 1'b0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  rd1 = 8'hEE, rd2 = 8'hEE;
  logic [15:0] wlog_a[$];
  logic [7:0]  wlog_d[$];

  always #5 clk = ~clk;

  sram_spi_arbiter dut (
    .clk(clk), .reset(reset), .page(page), .spi_rd_mode(spi_rd_mode), .start_addr(start_addr),
    .addr_load_stb(addr_load_stb), .spi_wr_stb(spi_wr_stb), .spi_wr_data(spi_wr_data),
    .spi_rd_stb(spi_rd_stb), .spi_rd_data(spi_rd_data), .aud_req(aud_req), .aud_we(aud_we),
    .aud_addr(aud_addr), .aud_wdata(aud_wdata), .aud_gnt(aud_gnt), .aud_rdata(aud_rdata),
    .aud_rvalid(aud_rvalid), .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .clr_err(clr_err),
    .wr_overflow(wr_overflow), .rd_underrun(rd_underrun), .spi_busy(spi_busy)
  );

  // SRAM: data for a read issued in cycle k is presented during cycle k+2.
  assign sram_rdata = rd2;
  always @(posedge clk) begin
    if (sram_en && sram_we) begin
      mem[sram_addr] <= sram_wdata;
      wlog_a.push_back(sram_addr);
      wlog_d.push_back(sram_wdata);
    end
    rd1 <= (sram_en && !sram_we) ? mem[sram_addr] : 8'hEE;
    rd2 <= rd1;
  end

  always @(negedge clk) begin
    if (aud_rvalid) rvalid_cnt <= rvalid_cnt + 1;
    if (aud_gnt && prev_gnt) consec <= consec + 1;
    prev_gnt <= aud_gnt;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load(input logic [7:0] pg, input logic [7:0] sa, input logic md);
    page = pg; start_addr = sa; spi_rd_mode = md; addr_load_stb = 1'b1;
    tick();
    addr_load_stb = 1'b0;
  endtask

  task automatic pulse_wr(input logic [7:0] d);
    spi_wr_data = d; spi_wr_stb = 1'b1;
    tick();
    spi_wr_stb = 1'b0;
  endtask

  task automatic pulse_rd();
    spi_rd_stb = 1'b1;
    tick();
    spi_rd_stb = 1'b0;
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (aud_gnt) begin ok = 1'b1; break; end
    end
  endtask

  task automatic aud_write(input logic [15:0] a, input logic [7:0] d);
    bit ok;
    aud_req = 1'b1; aud_we = 1'b1; aud_addr = a; aud_wdata = d;
    wait_gnt(ok);
    aud_req = 1'b0; aud_we = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL aud_write_gnt: addr %h got no grant, want grant", a); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) tick();
    checks++;
    if ({sram_en, sram_we, aud_gnt, aud_rvalid, wr_overflow, rd_underrun, spi_busy} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0000000",
               {sram_en, sram_we, aud_gnt, aud_rvalid, wr_overflow, rd_underrun, spi_busy});
    end
    checks++;
    if ({sram_addr, sram_wdata, aud_rdata, spi_rd_data} !== 40'd0) begin
      errors++;
      $display("FAIL reset_data: got %h want 0", {sram_addr, sram_wdata, aud_rdata, spi_rd_data});
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_spi_write_wrap();
    logic [15:0] ea [3];
    logic [7:0]  ed [3];
    int base;
    ea[0] = 16'h03FE; ea[1] = 16'h03FF; ea[2] = 16'h0300;
    ed[0] = 8'hA1;    ed[1] = 8'hA2;    ed[2] = 8'hA3;
    base = wlog_a.size();
    pulse_load(8'h03, 8'hFE, 1'b0);
    for (int i = 0; i < 3; i++) begin
      pulse_wr(ed[i]);
      repeat (3) tick();
    end
    tick();
    checks++;
    if (wlog_a.size() - base !== 3) begin
      errors++; $display("FAIL wrap_count: got %0d writes want 3", wlog_a.size() - base);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if ({wlog_a[base+i], wlog_d[base+i]} !== {ea[i], ed[i]}) begin
          errors++;
          $display("FAIL wrap_write%0d: got %h=%h want %h=%h", i, wlog_a[base+i], wlog_d[base+i], ea[i], ed[i]);
        end
      end
    end
    checks++;
    if ({wr_overflow, spi_busy} !== 2'b00) begin
      errors++; $display("FAIL wrap_flags: got ovf=%b busy=%b want 0 0", wr_overflow, spi_busy);
    end
  endtask

  task automatic test_audio();
    bit ok;
    aud_write(16'h0010, 8'h11);
    aud_write(16'h0011, 8'h22);
    aud_write(16'h0012, 8'h33);
    aud_req = 1'b1; aud_we = 1'b0; aud_addr = 16'h0012;
    wait_gnt(ok);
    aud_req = 1'b0;
    tick(); tick();
    checks++;
    if (aud_rvalid !== 1'b0) begin errors++; $display("FAIL aud_rd_early: got rvalid=%b want 0", aud_rvalid); end
    tick();
    checks++;
    if ({ok, aud_rvalid, aud_rdata} !== {1'b1, 1'b1, 8'h33}) begin
      errors++; $display("FAIL aud_rd: got gnt=%b rvalid=%b data=%h want 1 1 33", ok, aud_rvalid, aud_rdata);
    end
    tick();
  endtask

  task automatic test_prefetch();
    pulse_load(8'h00, 8'h10, 1'b1);
    tick();
    checks++;
    if ({sram_en, sram_we, sram_addr} !== {1'b1, 1'b0, 16'h0010}) begin
      errors++; $display("FAIL pf_issue: got en=%b we=%b addr=%h want 1 0 0010", sram_en, sram_we, sram_addr);
    end
    tick(); tick();
    checks++;
    if (spi_rd_data !== 8'h00) begin errors++; $display("FAIL pf_early: got %h want 00", spi_rd_data); end
    tick();
    checks++;
    if (spi_rd_data !== 8'h11) begin errors++; $display("FAIL pf_first: got %h want 11", spi_rd_data); end
    pulse_rd();
    repeat (5) tick();
    checks++;
    if (spi_rd_data !== 8'h22) begin errors++; $display("FAIL pf_second: got %h want 22", spi_rd_data); end
    pulse_rd();
    repeat (5) tick();
    checks++;
    if ({spi_rd_data, rd_underrun} !== {8'h33, 1'b0}) begin
      errors++; $display("FAIL pf_third: got %h unr=%b want 33 0", spi_rd_data, rd_underrun);
    end
  endtask

  task automatic test_starvation();
    bit ok, spi_seen, after_ok;
    int n_aud;
    logic [15:0] wa;
    logic [7:0]  wd;
    spi_seen = 1'b0; after_ok = 1'b0; n_aud = 0; wa = '0; wd = '0;
    aud_req = 1'b1; aud_we = 1'b0; aud_addr = 16'h0040;
    wait_gnt(ok);
    pulse_wr(8'h5A);
    for (int i = 0; i < 80; i++) begin
      tick();
      if (sram_en) begin
        if (sram_we && !spi_seen) begin
          spi_seen = 1'b1; wa = sram_addr; wd = sram_wdata;
        end else if (aud_gnt) begin
          if (spi_seen) begin after_ok = 1'b1; break; end
          n_aud++;
        end
      end
    end
    aud_req = 1'b0;
    repeat (5) tick();
    checks++;
    if ({ok, spi_seen, n_aud} !== {1'b1, 1'b1, 32'd4}) begin
      errors++; $display("FAIL starve_wait: got first_gnt=%b spi=%b lost=%0d want 1 1 4", ok, spi_seen, n_aud);
    end
    checks++;
    if ({wa, wd} !== {16'h0013, 8'h5A}) begin
      errors++; $display("FAIL starve_write: got %h=%h want 0013=5a", wa, wd);
    end
    checks++;
    if (after_ok !== 1'b1) begin errors++; $display("FAIL starve_resume: got %b want 1", after_ok); end
    checks++;
    if (consec !== 0) begin errors++; $display("FAIL gnt_consecutive: got %0d want 0", consec); end
  endtask

  task automatic test_overflow();
    bit ok;
    int base;
    base = wlog_a.size();
    aud_req = 1'b1; aud_we = 1'b0; aud_addr = 16'h0040;
    wait_gnt(ok);
    spi_wr_data = 8'h77; spi_wr_stb = 1'b1;
    tick();
    checks++;
    if (wr_overflow !== 1'b0) begin errors++; $display("FAIL ovf_first: got %b want 0", wr_overflow); end
    spi_wr_data = 8'h88;
    tick();
    spi_wr_stb = 1'b0;
    checks++;
    if (wr_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", wr_overflow); end
    aud_req = 1'b0;
    repeat (30) tick();
    checks++;
    if (wlog_a.size() - base !== 1) begin
      errors++; $display("FAIL ovf_count: got %0d writes want 1", wlog_a.size() - base);
    end else begin
      checks++;
      if ({wlog_a[base], wlog_d[base]} !== {16'h0014, 8'h77}) begin
        errors++; $display("FAIL ovf_kept: got %h=%h want 0014=77", wlog_a[base], wlog_d[base]);
      end
    end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (wr_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clr: got %b want 0", wr_overflow); end
    pulse_wr(8'h99);
    repeat (3) tick();
    checks++;
    if (wlog_a.size() - base !== 2) begin
      errors++; $display("FAIL ovf_next_count: got %0d writes want 2", wlog_a.size() - base);
    end else begin
      checks++;
      if ({wlog_a[base+1], wlog_d[base+1]} !== {16'h0015, 8'h99}) begin
        errors++; $display("FAIL ovf_ptr: got %h=%h want 0015=99", wlog_a[base+1], wlog_d[base+1]);
      end
    end
  endtask

  task automatic test_underrun();
    pulse_load(8'h00, 8'h10, 1'b1);
    tick();
    pulse_rd();
    checks++;
    if ({rd_underrun, spi_rd_data} !== {1'b1, 8'h33}) begin
      errors++; $display("FAIL unr_set: got unr=%b data=%h want 1 33", rd_underrun, spi_rd_data);
    end
    tick();
    checks++;
    if (spi_rd_data !== 8'h33) begin errors++; $display("FAIL unr_hold: got %h want 33", spi_rd_data); end
    tick();
    checks++;
    if (spi_rd_data !== 8'h11) begin errors++; $display("FAIL unr_done: got %h want 11", spi_rd_data); end
    repeat (5) tick();
    checks++;
    if (spi_rd_data !== 8'h22) begin errors++; $display("FAIL unr_refetch: got %h want 22", spi_rd_data); end
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks++;
    if (rd_underrun !== 1'b0) begin errors++; $display("FAIL unr_clr: got %b want 0", rd_underrun); end
  endtask

  task automatic test_stale();
    bit seen11;
    seen11 = 1'b0;
    pulse_load(8'h00, 8'h10, 1'b1);
    tick();
    pulse_load(8'h00, 8'h12, 1'b1);
    for (int i = 0; i < 12; i++) begin
      tick();
      if (spi_rd_data === 8'h11) seen11 = 1'b1;
    end
    checks++;
    if ({seen11, spi_rd_data} !== {1'b0, 8'h33}) begin
      errors++; $display("FAIL stale: got seen11=%b data=%h want 0 33", seen11, spi_rd_data);
    end
  endtask

  task automatic test_reset_midread();
    bit ok;
    int rv0, base;
    aud_req = 1'b1; aud_we = 1'b0; aud_addr = 16'h0011;
    wait_gnt(ok);
    aud_req = 1'b0;
    tick();
    rv0 = rvalid_cnt;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({sram_en, sram_we, aud_gnt, aud_rvalid, wr_overflow, rd_underrun, spi_busy,
         sram_addr, sram_wdata, aud_rdata, spi_rd_data} !== 47'd0) begin
      errors++; $display("FAIL midread_outputs: got %h want 0",
        {sram_en, sram_we, aud_gnt, aud_rvalid, wr_overflow, rd_underrun, spi_busy,
         sram_addr, sram_wdata, aud_rdata, spi_rd_data});
    end
    repeat (2) tick();
    reset = 1'b0;
    repeat (6) tick();
    checks++;
    if (rvalid_cnt !== rv0) begin errors++; $display("FAIL midread_rvalid: got %0d want %0d", rvalid_cnt, rv0); end
    base = wlog_a.size();
    pulse_wr(8'hC3);
    repeat (3) tick();
    checks++;
    if (wlog_a.size() - base !== 1) begin
      errors++; $display("FAIL midread_ptr_count: got %0d want 1", wlog_a.size() - base);
    end else begin
      checks++;
      if (wlog_a[base] !== 16'h0000) begin errors++; $display("FAIL midread_ptr: got %h want 0000", wlog_a[base]); end
    end
    aud_req = 1'b1; aud_we = 1'b0; aud_addr = 16'h0011;
    wait_gnt(ok);
    aud_req = 1'b0;
    repeat (3) tick();
    checks++;
    if ({ok, aud_rvalid, aud_rdata} !== {1'b1, 1'b1, 8'h22}) begin
      errors++; $display("FAIL midread_regrant: got gnt=%b rvalid=%b data=%h want 1 1 22", ok, aud_rvalid, aud_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_spi_write_wrap();
    test_audio();
    test_prefetch();
    test_starvation();
    test_overflow();
    test_underrun();
    test_stale();
    test_reset_midread();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded 100000 time units");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sram_spi_arbiter.md
Name: sram_spi_arbiter

Overview:
- Shares one single-port audio SRAM between two requesters: the SPI register path (SPI_TO_SRAM writes, SRAM_TO_SPI reads) and the audio datapath.
- SPI accesses auto-increment a 16-bit pointer built as {page, start offset}. SPI reads are prefetched so that data is ready before the next SPI read strobe.
- Audio has priority. A starvation guard bounds how long SPI can wait.

Parameters:
- ADDR_W, 16, SRAM address width; the pointer is {page[7:0], offset[7:0]}.
- DATA_W, 8, SRAM data width.
- RD_LATENCY, 2, clocks from the issue cycle to valid sram_rdata (1..7).
- MAX_WAIT, 4, consecutive lost SPI arbitration cycles before SPI is forced to win.

Ports:
- clk  in  1  single system clock.
- reset  in  1  asynchronous, active-high reset.
- page  in  8  SRAM page (sram_control_reg[6:0] zero-extended by the top level).
- spi_rd_mode  in  1  sram_control_reg[7]; 1 = prefetch on address load.
- start_addr  in  8  sram_start_addr_reg.
- addr_load_stb  in  1  one-clk pulse when SRAM_ADDR is written.
- spi_wr_stb  in  1  one-clk pulse when SPI_TO_SRAM is written.
- spi_wr_data  in  8  spi_to_sram_reg.
- spi_rd_stb  in  1  one-clk pulse when SRAM_TO_SPI is read.
- spi_rd_data  out  8  prefetched data (drives sram_to_spi_data).
- aud_req  in  1  audio request; held until aud_gnt.
- aud_we  in  1  audio write enable.
- aud_addr  in  16  audio address.
- aud_wdata  in  8  audio write data.
- aud_gnt  out  1  one-clk pulse in the issue cycle.
- aud_rdata  out  8  audio read data.
- aud_rvalid  out  1  one-clk pulse marking aud_rdata valid.
- sram_en  out  1  SRAM access enable.
- sram_we  out  1  SRAM write enable.
- sram_addr  out  16  SRAM address.
- sram_wdata  out  8  SRAM write data.
- sram_rdata  in  8  SRAM read data.
- clr_err  in  1  clears the sticky error flags.
- wr_overflow  out  1  sticky error flag.
- rd_underrun  out  1  sticky error flag.
- spi_busy  out  1  SPI write or prefetch pending or in flight.

Behaviour:
- Reset:
  - All outputs are 0; the pointer is 0; pending flags are cleared; the wait counter is 0; state is IDLE.
  - Reset mid-read aborts the read; no rvalid is produced.
- Signal timing:
  - sram_*, aud_gnt and aud_rvalid are registered.
  - The issue cycle is the cycle in which sram_en=1.
- SPI write slot (one entry):
  - spi_wr_stb with the slot empty captures {pointer, spi_wr_data} and increments the pointer.
  - spi_wr_stb with the slot full sets wr_overflow and drops the write; the pointer is unchanged.
- Address load:
  - addr_load_stb sets pointer <= {page, start_addr}.
  - If spi_rd_mode=1, it also sets prefetch_pending.
  - A prefetch already in flight is marked stale; its data is discarded and does not update spi_rd_data.
  - A queued write keeps its captured address.
- Prefetch:
  - A prefetch issue reads the pointer and increments it.
  - On completion, spi_rd_data <= sram_rdata.
- SPI read strobe:
  - spi_rd_stb sets prefetch_pending.
  - If a prefetch is pending or in flight at the strobe, set rd_underrun; spi_rd_data holds its old value.
- Pointer wrap: the offset wraps 0xFF->0x00 within the page; the page never increments.
- Simultaneous SPI strobes: addr_load_stb and spi_wr_stb in the same cycle means the write uses the old pointer and the load wins the final pointer value.
- Arbitration (evaluated only in IDLE):
  - Eligible requesters are audio (aud_req=1, not granted in the previous cycle), SPI write (slot full) and SPI prefetch (pending).
  - Audio wins unless wait_cnt==MAX_WAIT.
  - Between the SPI requesters, write beats prefetch.
  - wait_cnt increments each IDLE cycle in which SPI is eligible and loses, and clears when SPI wins.
- Re-grant rule: audio is ineligible for the cycle after its grant, so the requester can drop aud_req.
- FSM states:
  - IDLE: a write issues in one cycle and the FSM stays in IDLE. A read issues and goes to RD_WAIT with cnt=RD_LATENCY.
  - RD_WAIT: cnt decrements; no access issues. At cnt==1, sram_rdata is captured and the FSM returns to IDLE.
- Read latency: aud_rvalid/aud_rdata (or the spi_rd_data update) become visible RD_LATENCY+1 clocks after the issue cycle.
- No owner pending: sram_en=0 and the other sram_* outputs hold.
- Error flags: wr_overflow and rd_underrun are sticky until clr_err. If clr_err coincides with a new error event, the flag is set.
- spi_busy = slot full | prefetch_pending | SPI read in flight.

Test Plan:
- Reset, then page=0x03, start_addr=0xFE, spi_rd_mode=0, load. Then three spi_wr_stb with data 0xA1, 0xA2, 0xA3 spaced 4 clks apart, no audio. Required: SRAM writes 0x03FE=0xA1, 0x03FF=0xA2, 0x0300=0xA3 (wrap); wr_overflow=0.
- spi_rd_mode=1, load 0x0010 with mem[0x10..0x12]=0x11,0x22,0x33. Required: spi_rd_data=0x11 RD_LATENCY+1 clks after the issue. spi_rd_stb then yields 0x22, and a second strobe yields 0x33.
- Hold aud_req=1 continuously (reads), with an SPI write pending. Required: the SPI write issues after exactly MAX_WAIT=4 lost cycles, then audio resumes. Audio grants are never in consecutive cycles.
- Two spi_wr_stb in back-to-back cycles while audio holds the SRAM. Required: the first is kept, wr_overflow=1, the second write never appears on SRAM. clr_err clears the flag.
- spi_rd_stb while a prefetch is in flight. Required: rd_underrun=1 and spi_rd_data unchanged until the fetch completes.
- Assert reset during RD_WAIT of an audio read. Required: no aud_rvalid, all outputs 0, the pointer is 0; after reset release a new aud_req is granted normally.
